line_editor: RTL and testbench



---
 rtl/line_editor.sv | 115 +++++++++++
 tb/tb_line_editor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/line_editor.sv
// line_editor: character line buffer between a keyboard source and a monitor sink.
// Collects characters in FILL until LF or a full line, then drains the whole line
// downstream in DRAIN with the final character flagged by out_last.
// Optional feature macro: LINE_EDITOR_BS_EN (0x08 acts as backspace when defined,
// otherwise it is stored as an ordinary character).
module line_editor #(
    parameter int unsigned DEPTH = 100,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_char,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    localparam logic [7:0] CharNul = 8'h00;
`ifdef LINE_EDITOR_BS_EN
    localparam logic [7:0] CharBs  = 8'h08;
`endif
    localparam logic [7:0] CharLf  = 8'h0A;

    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             wr_en;

    // Line storage; not reset, entries beyond count are never read out.
    logic [7:0]       line_buf_q [DEPTH];

    assign in_ready  = (state_q == StFill);
    assign out_valid = (state_q == StDrain);
    assign out_char  = line_buf_q[rd_ptr_q];
    assign out_last  = out_valid && (rd_ptr_q == count_q - 1'b1);
    assign count     = count_q;

    // Control state, count and read pointer registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StFill;
            count_q  <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Character store at the current write index (= count).
    always_ff @(posedge clock) begin
        if (wr_en) begin
            line_buf_q[count_q] <= in_char;
        end
    end

    // Next-state: classify accepted characters in FILL, advance the read side in DRAIN.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_en    = 1'b0;
        unique case (state_q)
            StFill: begin
                if (in_valid) begin
                    case (in_char)
                        CharNul: begin
                            // Discarded.
                        end
`ifdef LINE_EDITOR_BS_EN
                        CharBs: begin
                            if (count_q != '0) begin
                                count_d = count_q - 1'b1;
                            end
                        end
`endif
                        CharLf: begin
                            wr_en   = 1'b1;
                            count_d = count_q + 1'b1;
                            state_d = StDrain;
                        end
                        default: begin
                            wr_en   = 1'b1;
                            count_d = count_q + 1'b1;
                            // Forced line break once the buffer is full.
                            if (count_q == CNT_W'(DEPTH - 1)) begin
                                state_d = StDrain;
                            end
                        end
                    endcase
                end
            end
            StDrain: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d  = StFill;
                        count_d  = '0;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

endmodule

// File: tb/tb_line_editor.sv
// Directed testbench for line_editor. Inputs change and outputs are sampled 1ns
// after the rising clock edge.
module tb_line_editor;

    localparam int unsigned DEPTH = 100;
    localparam int unsigned CNT_W = 7;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_char = 8'h00;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_char;
    logic             out_last;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;

    line_editor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_char  (out_char),
        .out_last  (out_last),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one character for exactly one cycle; FILL must be ready.
    task automatic send(input logic [7:0] c);
        check("send_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_char  = c;
        step();
        in_valid = 1'b0;
    endtask

    // Take one character with out_ready high, checking data and last flag first.
    task automatic recv(input logic [7:0] c, input logic last);
        check("recv_out_valid", 32'(out_valid), 32'd1);
        check("recv_out_char", 32'(out_char), 32'(c));
        check("recv_out_last", 32'(out_last), 32'(last));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state.
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        step();

        // Line "hi\n".
        send(8'h68);
        send(8'h69);
        check("hi_pre_lf_out_valid", 32'(out_valid), 32'd0);
        send(8'h0A);
        check("hi_out_valid_after_lf", 32'(out_valid), 32'd1);
        check("hi_in_ready_drain", 32'(in_ready), 32'd0);
        check("hi_count", 32'(count), 32'd3);
        recv(8'h68, 1'b0);
        recv(8'h69, 1'b0);
        recv(8'h0A, 1'b1);
        check("hi_in_ready_after", 32'(in_ready), 32'd1);
        check("hi_count_after", 32'(count), 32'd0);

        // Editing sequence.
        send(8'h08);
        send(8'h61);
        send(8'h62);
        send(8'h08);
        send(8'h00);
        send(8'h63);
        send(8'h0A);
`ifdef LINE_EDITOR_BS_EN
        check("edit_count", 32'(count), 32'd3);
        recv(8'h61, 1'b0);
        recv(8'h63, 1'b0);
        recv(8'h0A, 1'b1);
`else
        check("edit_count", 32'(count), 32'd6);
        recv(8'h08, 1'b0);
        recv(8'h61, 1'b0);
        recv(8'h62, 1'b0);
        recv(8'h08, 1'b0);
        recv(8'h63, 1'b0);
        recv(8'h0A, 1'b1);
`endif
        check("edit_in_ready_after", 32'(in_ready), 32'd1);

        // Backpressure on "ab\n": out_ready low for 5 cycles before each transfer.
        send(8'h61);
        send(8'h62);
        send(8'h0A);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_a", 32'(out_char), 32'h61);
            check("bp_hold_a_last", 32'(out_last), 32'd0);
        end
        recv(8'h61, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_b", 32'(out_char), 32'h62);
            check("bp_hold_b_valid", 32'(out_valid), 32'd1);
        end
        recv(8'h62, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_lf", 32'(out_char), 32'h0A);
        end
        recv(8'h0A, 1'b1);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_out_valid_after", 32'(out_valid), 32'd0);

        // Full line of 100 'x' without LF.
        for (int i = 0; i < int'(DEPTH); i++) begin
            send(8'h78);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_count", 32'(count), 32'd100);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == int'(DEPTH) - 1) begin
                check("full_count_before_last", 32'(count), 32'd100);
            end
            recv(8'h78, (i == int'(DEPTH) - 1));
        end
        check("full_in_ready_after", 32'(in_ready), 32'd1);
        check("full_count_after", 32'(count), 32'd0);

        // Reset mid-drain after 2 of 5 characters.
        send(8'h76);
        send(8'h77);
        send(8'h78);
        send(8'h79);
        send(8'h0A);
        recv(8'h76, 1'b0);
        recv(8'h77, 1'b0);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_char  = 8'h41;
        out_ready = 1'b1;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_last", 32'(out_last), 32'd0);
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        step();
        step();
        check("mrst_count_held", 32'(count), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b1;
        step();
        check("mrst_count_release", 32'(count), 32'd0);
        send(8'h7A);
        send(8'h0A);
        check("z_count", 32'(count), 32'd2);
        recv(8'h7A, 1'b0);
        recv(8'h0A, 1'b1);
        check("z_in_ready_after", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
